// File: rtl/minimax_search_param.sv
// rtl/minimax_search_param.sv - two-ply max-min move selector for a COLS x ROWS drop-column board
`timescale 1ns/1ps
module minimax_search_param #(
   parameter int COLS    = 7,
   parameter int ROWS    = 6,
   parameter int CNT_W   = 3,
   parameter int SCORE_W = 9
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      enable,
   input  logic [2*COLS*ROWS-1:0]    grid_in,
   input  logic [CNT_W*COLS-1:0]     col_counts_in,
   output logic                      busy,
   output logic                      done,
   output logic                      move_valid,
   output logic [3:0]                best_col,
   output logic signed [SCORE_W-1:0] best_score,
   output logic                      eval_req,
   output logic [2*COLS*ROWS-1:0]    eval_grid,
   input  logic                      eval_ack,
   input  logic signed [SCORE_W-1:0] eval_score
);
   localparam int GW = 2*COLS*ROWS;

   typedef enum logic [2:0] {IDLE, AI_SEL, OPP_SEL, REQ, WAIT, AI_UPD, DONE} state_t;

   state_t                     state, state_nx;
   logic [GW-1:0]              grid_q;
   logic [CNT_W*COLS-1:0]      cnt_q;
   logic [GW-1:0]              g1;
   logic [3:0]                 a, o;
   logic                       min_valid, leaf, move_found;
   logic signed [SCORE_W-1:0]  cur_min, best_q;
   logic [3:0]                 best_col_int;
   logic [CNT_W-1:0]           h_ai, h_opp;
   logic                       a_end, o_end, ai_full, opp_full;

   // Filled height of one column, selected by a loop mux so any COLS works.
   function automatic logic [CNT_W-1:0] height_of(input logic [CNT_W*COLS-1:0] cnts,
                                                   input logic [3:0] col);
      height_of = '0;
      for (int c = 0; c < COLS; c++)
         if (col == 4'(c)) height_of = cnts[CNT_W*c +: CNT_W];
   endfunction

   // Board copy with one cell overwritten by the given piece code.
   function automatic logic [GW-1:0] put(input logic [GW-1:0] g, input logic [CNT_W-1:0] row,
                                          input logic [3:0] col, input logic [1:0] piece);
      put = g;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (row == CNT_W'(r) && col == 4'(c)) put[2*(r*COLS+c) +: 2] = piece;
   endfunction

   // Column selection terms; the opponent sees column a one piece taller.
   always_comb begin
      h_ai     = height_of(cnt_q, a);
      h_opp    = height_of(cnt_q, o) + CNT_W'(o == a);
      a_end    = (a == 4'(COLS));
      o_end    = (o == 4'(COLS));
      ai_full  = (h_ai >= CNT_W'(ROWS));
      opp_full = (h_opp >= CNT_W'(ROWS));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; dropping enable abandons any search.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start && enable) state_nx = AI_SEL;
         AI_SEL:  if (a_end) state_nx = DONE;
                  else if (!ai_full) state_nx = OPP_SEL;
         OPP_SEL: if (o_end) state_nx = min_valid ? AI_UPD : REQ;
                  else if (!opp_full) state_nx = REQ;
         REQ:     state_nx = WAIT;
         WAIT:    if (eval_ack) state_nx = leaf ? AI_UPD : OPP_SEL;
         AI_UPD:  state_nx = AI_SEL;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (state != IDLE && !enable) state_nx = IDLE;
   end

   // Status outputs decoded from state.
   always_comb begin
      busy     = (state != IDLE) && (state != DONE);
      done     = (state == DONE);
      eval_req = (state == WAIT);
   end

   // Search datapath: board copies, loop indices, running min and max.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grid_q       <= '0;
         cnt_q        <= '0;
         g1           <= '0;
         a            <= '0;
         o            <= '0;
         min_valid    <= 1'b0;
         leaf         <= 1'b0;
         move_found   <= 1'b0;
         cur_min      <= '0;
         best_q       <= '0;
         best_col_int <= '0;
         move_valid   <= 1'b0;
         best_col     <= '0;
         best_score   <= '0;
         eval_grid    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && enable) begin
                  grid_q       <= grid_in;
                  cnt_q        <= col_counts_in;
                  a            <= '0;
                  move_found   <= 1'b0;
                  best_col_int <= '0;
                  best_q       <= '0;
               end
            end
            AI_SEL: begin
               if (a_end) begin
                  if (enable) begin
                     move_valid <= move_found;
                     best_col   <= move_found ? best_col_int : 4'd0;
                     best_score <= move_found ? best_q : '0;
                  end
               end else if (ai_full) begin
                  a <= a + 4'd1;
               end else begin
                  g1        <= put(grid_q, h_ai, a, 2'b10);
                  o         <= '0;
                  min_valid <= 1'b0;
               end
            end
            OPP_SEL: begin
               if (o_end) begin
                  if (!min_valid) begin
                     eval_grid <= g1;
                     leaf      <= 1'b1;
                  end
               end else if (opp_full) begin
                  o <= o + 4'd1;
               end else begin
                  eval_grid <= put(g1, h_opp, o, 2'b01);
                  leaf      <= 1'b0;
               end
            end
            WAIT: begin
               if (eval_ack) begin
                  if (leaf) begin
                     cur_min <= eval_score;
                  end else begin
                     if (!min_valid || eval_score < cur_min) begin
                        cur_min   <= eval_score;
                        min_valid <= 1'b1;
                     end
                     o <= o + 4'd1;
                  end
               end
            end
            AI_UPD: begin
               if (!move_found || cur_min > best_q) begin
                  best_q       <= cur_min;
                  best_col_int <= a;
                  move_found   <= 1'b1;
               end
               a <= a + 4'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_minimax_search_param.sv
// tb/tb_minimax_search_param.sv - self-checking bench for minimax_search_param
`timescale 1ns/1ps
module tb_minimax_search_param;
   localparam int COLS = 7, ROWS = 6, CNT_W = 3, SW = 9, GW = 2*COLS*ROWS;

   logic                  clk = 1'b0, rst_n = 1'b0, start = 1'b0, enable = 1'b1;
   logic [GW-1:0]         grid_in = '0;
   logic [CNT_W*COLS-1:0] col_counts_in = '0;
   logic                  busy, done, move_valid, eval_req;
   logic [3:0]            best_col;
   logic signed [SW-1:0]  best_score;
   logic [GW-1:0]         eval_grid;
   logic                  eval_ack = 1'b0;
   logic signed [SW-1:0]  eval_score = '0;

   int vectors = 0, miscompares = 0;
   int mode = 0, max_delay = 0, req_count = 0, wait_cnt = 0;
   bit hold = 1'b0, in_req = 1'b0;
   logic [GW-1:0] req_grid = '0, last_grid = '0;
   int tb_board[ROWS][COLS];
   int tb_h[COLS];
   int prev_col = 0, prev_sc = 0, prev_mv = 0, last_cyc = 0;

   minimax_search_param #(.COLS(COLS), .ROWS(ROWS), .CNT_W(CNT_W), .SCORE_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .enable(enable),
      .grid_in(grid_in), .col_counts_in(col_counts_in),
      .busy(busy), .done(done), .move_valid(move_valid),
      .best_col(best_col), .best_score(best_score),
      .eval_req(eval_req), .eval_grid(eval_grid),
      .eval_ack(eval_ack), .eval_score(eval_score)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [GW-1:0] pack(input int b[ROWS][COLS]);
      pack = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            pack[2*(r*COLS+c) +: 2] = 2'(b[r][c]);
   endfunction

   // Scorer rules: constant, AI piece count, column-4 threat, board hash.
   function automatic int score_fn(input logic [GW-1:0] g, input int m);
      int s;
      s = 0;
      case (m)
         0: s = 5;
         1: for (int i = 0; i < COLS*ROWS; i++) if (g[2*i +: 2] == 2'b10) s++;
         2: begin
            s = 3;
            for (int r = 0; r < ROWS; r++) if (g[2*(r*COLS+4) +: 2] == 2'b01) s = -20;
         end
         default: begin
            for (int i = 0; i < COLS*ROWS; i++) s += (i + 3) * int'(g[2*i +: 2]) * (i % 5 + 1);
            s = (s % 401) - 200;
         end
      endcase
      return s;
   endfunction

   // Reference: enumerate every AI drop and every opponent reply on 2-D boards.
   task automatic model(output int col, output int sc, output int mv, output int nr);
      int b1[ROWS][COLS];
      int b2[ROWS][COLS];
      int m, s, eh, best;
      bit mvld, found;
      found = 0; best = 0; col = 0; nr = 0;
      for (int ac = 0; ac < COLS; ac++) begin
         if (tb_h[ac] < ROWS) begin
            b1 = tb_board;
            b1[tb_h[ac]][ac] = 2;
            mvld = 0; m = 0;
            for (int oc = 0; oc < COLS; oc++) begin
               eh = tb_h[oc] + ((oc == ac) ? 1 : 0);
               if (eh < ROWS) begin
                  b2 = b1;
                  b2[eh][oc] = 1;
                  s = score_fn(pack(b2), mode);
                  nr++;
                  if (!mvld || s < m) begin m = s; mvld = 1; end
               end
            end
            if (!mvld) begin m = score_fn(pack(b1), mode); nr++; end
            if (!found || m > best) begin best = m; col = ac; found = 1; end
         end
      end
      sc = found ? best : 0;
      mv = found ? 1 : 0;
   endtask

   task automatic clear_board();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) tb_board[r][c] = 0;
      for (int c = 0; c < COLS; c++) tb_h[c] = 0;
   endtask

   task automatic fill_col(input int c, input int n, input int who);
      tb_h[c] = n;
      for (int r = 0; r < n; r++)
         tb_board[r][c] = (who != 0) ? who : int'($urandom_range(1, 2));
   endtask

   task automatic apply_board();
      grid_in = pack(tb_board);
      for (int c = 0; c < COLS; c++) col_counts_in[CNT_W*c +: CNT_W] = CNT_W'(tb_h[c]);
   endtask

   // Scorer: answers each request after 0..max_delay cycles; hold suppresses acks.
   always @(negedge clk) begin
      if (eval_ack) eval_ack = 1'b0;
      else if (!eval_req) in_req = 1'b0;
      else if (!hold) begin
         if (!in_req) begin
            in_req   = 1'b1;
            req_grid = eval_grid;
            wait_cnt = (max_delay > 0) ? int'($urandom_range(0, max_delay)) : 0;
         end
         if (wait_cnt == 0) begin
            chk("grid_stable", eval_grid, req_grid);
            eval_score = SW'(score_fn(eval_grid, mode));
            eval_ack   = 1'b1;
            req_count++;
            last_grid  = eval_grid;
            in_req     = 1'b0;
         end else wait_cnt--;
      end
   end

   task automatic run_search(input int m, input int maxd);
      int col, sc, mv, nr, cyc;
      bit got;
      mode = m; max_delay = maxd; req_count = 0;
      apply_board();
      model(col, sc, mv, nr);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("busy_after_start", GW'(busy), GW'(1));
      cyc = 1; got = 0;
      while (!got && cyc < 5000) begin
         if (done) got = 1;
         else begin @(negedge clk); cyc++; end
      end
      chk("done_seen", GW'(got), GW'(1));
      chk("best_col", GW'(best_col), GW'(col));
      chk("best_score", GW'(best_score), GW'(SW'(sc)));
      chk("move_valid", GW'(move_valid), GW'(mv));
      chk("req_count", GW'(req_count), GW'(nr));
      chk("busy_at_done", GW'(busy), GW'(0));
      last_cyc = cyc;
      prev_col = col; prev_sc = sc; prev_mv = mv;
      @(negedge clk);
      chk("done_one_cycle", GW'(done), GW'(0));
   endtask

   initial begin
      int n;
      bit saw_done;
      int lb[ROWS][COLS];
      clear_board();
      apply_board();
      @(negedge clk);
      chk("rst_busy", GW'(busy), GW'(0));
      chk("rst_done", GW'(done), GW'(0));
      chk("rst_move_valid", GW'(move_valid), GW'(0));
      chk("rst_best_col", GW'(best_col), GW'(0));
      chk("rst_best_score", GW'(best_score), GW'(0));
      chk("rst_eval_req", GW'(eval_req), GW'(0));
      chk("rst_eval_grid", eval_grid, GW'(0));
      rst_n = 1'b1;

      // Empty board, constant scorer.
      clear_board();
      run_search(0, 0);

      // Only column 6 open, AI-count scorer.
      clear_board();
      for (int c = 0; c < COLS-1; c++) fill_col(c, ROWS, 0);
      run_search(1, 0);

      // Single open cell: one leaf request.
      clear_board();
      for (int c = 0; c < COLS; c++) fill_col(c, (c == 3) ? ROWS-1 : ROWS, 0);
      run_search(1, 0);
      lb = tb_board;
      lb[ROWS-1][3] = 2;
      chk("leaf_grid", last_grid, pack(lb));

      // Full board: no requests, quick done.
      clear_board();
      for (int c = 0; c < COLS; c++) fill_col(c, ROWS, 0);
      run_search(0, 0);
      chk("full_latency", GW'(last_cyc <= COLS+2), GW'(1));

      // Random boards with random scorer latency.
      for (int k = 0; k < 6; k++) begin
         clear_board();
         for (int c = 0; c < COLS; c++) fill_col(c, int'($urandom_range(0, ROWS)), 0);
         run_search((k % 2 == 1) ? 2 : 3, 3);
      end

      // Column-4 threat: only filling column 4 avoids the -20 reply.
      clear_board();
      fill_col(4, ROWS-1, 2);
      run_search(2, 7);

      // Abort while a request is outstanding.
      clear_board();
      apply_board();
      hold = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!eval_req && n < 50) begin @(negedge clk); n++; end
      chk("abort_req_high", GW'(eval_req), GW'(1));
      enable = 1'b0;
      @(negedge clk);
      chk("abort_busy", GW'(busy), GW'(0));
      chk("abort_eval_req", GW'(eval_req), GW'(0));
      chk("abort_done", GW'(done), GW'(0));
      chk("abort_hold_col", GW'(best_col), GW'(prev_col));
      chk("abort_hold_score", GW'(best_score), GW'(SW'(prev_sc)));
      chk("abort_hold_valid", GW'(move_valid), GW'(prev_mv));
      enable = 1'b1;
      hold = 1'b0;
      saw_done = 0;
      repeat (5) begin @(negedge clk); if (done) saw_done = 1; end
      chk("abort_no_done", GW'(saw_done), GW'(0));

      // Asynchronous reset in the middle of a search.
      hold = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy_before_reset", GW'(busy), GW'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", GW'(busy), GW'(0));
      chk("arst_done", GW'(done), GW'(0));
      chk("arst_move_valid", GW'(move_valid), GW'(0));
      chk("arst_best_col", GW'(best_col), GW'(0));
      chk("arst_best_score", GW'(best_score), GW'(0));
      chk("arst_eval_req", GW'(eval_req), GW'(0));
      chk("arst_eval_grid", eval_grid, GW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      hold = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", GW'(busy), GW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/minimax_search_param.md
Name: minimax_search_param

Overview:
- Parametrised successor to the fixed 7x6, 105-cycle two-ply move selector.
- Performs a two-ply (AI move, opponent reply) max-min search over an arbitrary COLS x ROWS drop-column board.
- Sequences hypothetical boards through an external scorer using a req/ack handshake of any latency.
- Sits between the game controller (which supplies board, column heights and start) and the display/move-commit logic (which consumes best_col on done).

Parameters:
- COLS, 7, number of columns (2..15).
- ROWS, 6, number of rows (2..15).
- CNT_W, 3, column-height counter width; must satisfy 2^CNT_W > ROWS.
- SCORE_W, 9, signed score width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a search; ignored while busy.
- enable  in  1  search permitted; low aborts any search in progress.
- grid_in  in  2*COLS*ROWS  board; cell (r,c) at bits [2*(r*COLS+c)+1 : 2*(r*COLS+c)]; 00 empty, 10 AI, 01 opponent; row 0 is the bottom.
- col_counts_in  in  CNT_W*COLS  filled height of column c at [CNT_W*c +: CNT_W].
- busy  out  1  search in progress.
- done  out  1  one-cycle pulse, search complete.
- move_valid  out  1  at least one legal AI move existed; held with best_col.
- best_col  out  4  chosen column; held until next done.
- best_score  out  SCORE_W  signed max-min score of best_col; held.
- eval_req  out  1  scorer request; level signal.
- eval_grid  out  2*COLS*ROWS  board to score; stable while eval_req is high.
- eval_ack  in  1  scorer response strobe.
- eval_score  in  SCORE_W  signed score; valid with eval_ack.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, move_valid=0, best_col=0, best_score=0, eval_req=0, eval_grid=0.
- IDLE: on start=1 and enable=1, latch grid_in and col_counts_in into internal copies, set a=0, go to AI_SEL, busy=1. All subsequent evaluation uses the latched copies only.
- AI_SEL:
  - If a==COLS, go to DONE.
  - If height[a] >= ROWS, increment a and stay in AI_SEL (one cycle per skipped column).
  - Otherwise, build g1 by writing 10 at (height[a], a), set o=0, set min_valid=0, go to OPP_SEL.
- OPP_SEL:
  - If o==COLS: if min_valid=0 (board full after the AI move), go to REQ with eval_grid=g1 (leaf); otherwise go to AI_UPD.
  - The effective height of column o is height[o], plus 1 if o==a.
  - If the effective height is >= ROWS, increment o.
  - Otherwise, write 01 at (effective height, o) into a copy of g1, drive it as eval_grid, and go to REQ.
- REQ/WAIT:
  - eval_req rises the cycle after entry and stays high until eval_ack is sampled high.
  - eval_req drops the following cycle.
  - eval_ack while eval_req=0 is ignored.
- Opponent-reply result: on ack, if min_valid=0 or eval_score < cur_min (signed compare), then cur_min=eval_score and min_valid=1. Then increment o and return to OPP_SEL.
- Leaf result: on ack after a leaf request, cur_min=eval_score, then go to AI_UPD.
- AI_UPD:
  - If move_found=0 or cur_min > best (strict, so ties keep the lower column), then best=cur_min, best_col_int=a, move_found=1.
  - Increment a and return to AI_SEL.
- DONE:
  - Copy best_col, best_score and move_valid (=move_found) to the outputs.
  - Pulse done for 1 cycle, clear busy, return to IDLE.
  - If no legal AI move existed: move_valid=0, best_col=0, best_score=0.
- Abort: enable=0 in any non-IDLE state returns to IDLE next cycle.
  - busy=0 and eval_req=0; no done pulse.
  - Held outputs keep their previous values.
  - A late eval_ack is ignored.
- Minimum latency per evaluation is 3 cycles (select, req, ack); total latency depends on the scorer.
- The arithmetic is signed SCORE_W throughout, with no saturation.

Test Plan:
- Empty 7x6 board, scorer acks in 1 cycle with a constant 5 -> 49 requests, done with best_col=0, best_score=5, move_valid=1.
- Columns 0-5 full, column 6 height 0, scorer returns the cell count of AI pieces -> best_col=6, best_score matches the model, no requests issued for columns 0-5.
- Board full except the top cell of column 3 -> exactly 1 leaf request with that cell set to 10; done with best_col=3.
- Full board -> no eval_req, done within COLS+2 cycles of start, move_valid=0, best_col=0.
- Scorer scores -20 on any board where the opponent occupies column 4, else +3, with random ack delays of 0-7 cycles -> max-min picks the lowest column whose replies avoid -20; results match the model irrespective of delay.
- enable dropped mid-WAIT with eval_req high -> eval_req low and busy low next cycle, no done; then rst_n pulsed mid-search -> all outputs return to their reset values asynchronously.
